ftoi_pipe: RTL and testbench
============================

# ftoi_pipe

Parametrised, handshaked successor to the fixed 32-bit `ftoi` converter. It converts IEEE-754 binary32 values to OUT_W-bit signed or unsigned integers under one of four per-transaction rounding modes, and raises exception flags. It is a 3-stage pipeline with valid/ready flow control, sitting between the FPU issue stage and the integer writeback path. The existing `ftoi` behaviour is mode RNA, signed, OUT_W=32; the exception is that positive overflow now saturates to +max instead of 0x80000000.

## Interface
- OUT_W, 32: result width, legal 8..64.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input transfer request.
- in_ready  out  1  pipeline can accept.
- x  in  32  binary32 operand.
- rm  in  2  rounding mode: 00 RNA (nearest, ties away from zero), 01 RTZ, 10 RDN (floor), 11 RUP (ceil).
- is_signed  in  1  1 = signed result, 0 = unsigned.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- y  out  OUT_W  integer result.
- nv  out  1  invalid flag.
- nx  out  1  inexact flag.

## Operation
- Decode: s=x[31], e=x[30:23], m=x[22:0]. Significand is {e!=0, m}; denormals count as nonzero magnitudes below 1.
- Exact magnitude: integer part I = floor(|x|). Fraction split into G (first bit below the binary point) and S (OR of all lower bits).
- Round increment:
  - RNA: G.
  - RTZ: 0.
  - RDN: s&(G|S).
  - RUP: ~s&(G|S).
- Rounded magnitude R = I + inc, computed OUT_W+1 bits wide so carry-out is caught.
- Range check:
  - Signed: valid if R ≤ 2^(OUT_W-1)-1 for s=0, or R ≤ 2^(OUT_W-1) for s=1.
  - Unsigned: valid if R ≤ 2^OUT_W-1 for s=0, or R==0 for s=1.
  - Any e ≥ 127+OUT_W is out of range.
- Result when in range: s ? -R : R, truncated to OUT_W bits. nv=0. nx=G|S.
- Result when out of range, or ±Inf: saturate.
  - Signed: +max 0x7F..F or min 0x80..0, by sign.
  - Unsigned: all-ones for positive, 0 for negative.
  - nv=1, nx=0.
- NaN (e=FF, m≠0): signed → +max, unsigned → all-ones. nv=1, nx=0.
- ±0: y=0, nv=0, nx=0.

## Timing
- Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
- adv = ~out_valid | out_ready. in_ready = adv, combinational from out_ready only.
- Pipeline stages, each with its own valid bit, all advancing together on adv (no bubble collapsing):
  - S1: register x, rm, is_signed.
  - S2: alignment shift, G/S, increment decision registered.
  - S3: add, range check, negate/saturate, flags registered into y/nv/nx.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- While out_valid & ~out_ready, y/nv/nx/out_valid hold stable and in_ready=0.
- Reset: all stage valids, out_valid, y, nv, nx go to 0. In-flight operations are dropped. in_ready is 1 in the first cycle after reset deasserts.
- rm and is_signed are sampled with x. Changing them mid-flight affects only later transfers.

## Structure
- Package `ftoi_pkg`:
  - rounding-mode constants RM_RNA/RM_RTZ/RM_RDN/RM_RUP;
  - binary32 field widths and exponent bias 127;
  - function for the OUT_W-dependent saturation constants.
- Sub-module `ftoi_align`: combinational; (e, m, OUT_W) → (I, G, S, too_big). It is instantiated in S2.
- Top level holds the valid/adv control, the S3 add and the saturation logic.

## Test plan
- 0x40200000 (2.5), signed, OUT_W=32 → y=3/2/2/3 for RNA/RTZ/RDN/RUP. nx=1 in all modes.
- 0xC0200000 (-2.5) → RNA 0xFFFFFFFD, RDN 0xFFFFFFFD, RUP 0xFFFFFFFE, RTZ 0xFFFFFFFE. nx=1.
- Signed limits:
  - 0x4F000000 (2^31) signed → 0x7FFFFFFF, nv=1.
  - 0xCF000000 (-2^31) signed → 0x80000000, nv=0.
  - 0x4F000000 unsigned → 0x80000000, nv=0.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, nv=1.
- OUT_W=8:
  - 0x42FF0000 (127.5) RNA signed → 0x7F, nv=1 (rounding carry).
  - 0xBF000000 (-0.5) RTZ unsigned → 0, nv=0, nx=1.
  - 0xBF000000 RDN unsigned → 0, nv=1.
- Back-to-back stream of 8 operands:
  - Hold out_ready=0 for 4 cycles mid-stream → in_ready=0 and y stable throughout the stall.
  - All 8 results arrive in order with none lost or duplicated.
- Assert rst for 1 cycle with 3 operations in flight → out_valid=0 next cycle. No stale result ever emerges. A new operand returns its result 3 cycles later.

Source files
------------

// File: rtl/ftoi_pkg.sv
// Shared constants and helpers for the binary32 -> integer conversion pipeline.
package ftoi_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = MAN_W + 1;
    localparam int BIAS  = 127;

    localparam logic [1:0] RM_RNA = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Saturation value in the low w bits: +max/min when signed, all-ones/zero when unsigned.
    function automatic logic [63:0] sat_value(input int w, input logic is_signed, input logic neg);
        logic [63:0] ones;
        logic [63:0] msb;
        ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = 64'd1 << (w - 1);
        if (is_signed)
            sat_value = neg ? msb : (msb - 64'd1);
        else
            sat_value = neg ? 64'd0 : ones;
    endfunction

endpackage

// File: rtl/ftoi_align.sv
// Splits |x| into integer part, guard bit and sticky bit; flags exponents too large for OUT_W.
module ftoi_align
    import ftoi_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic [EXP_W-1:0] e,
    input  logic [MAN_W-1:0] m,
    output logic [OUT_W-1:0] int_part,
    output logic             guard,
    output logic             sticky,
    output logic             too_big
);

    localparam int V_W = OUT_W + MAN_W;

    logic [SIG_W-1:0] sig;
    logic [EXP_W-1:0] k;
    logic [V_W-1:0]   v;

    assign sig     = {e != '0, m};
    assign k       = e - EXP_W'(BIAS);
    assign too_big = e >= EXP_W'(BIAS + OUT_W);

    // Binary point sits between v[MAN_W] and v[MAN_W-1] after shifting by the unbiased exponent.
    always_comb begin
        v        = '0;
        int_part = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        if (e >= EXP_W'(BIAS)) begin
            v        = V_W'(sig) << k;
            int_part = v[V_W-1:MAN_W];
            guard    = v[MAN_W-1];
            sticky   = |v[MAN_W-2:0];
        end else if (e == EXP_W'(BIAS - 1)) begin
            guard  = 1'b1;
            sticky = |m;
        end else begin
            sticky = |sig;
        end
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage valid/ready binary32 -> OUT_W-bit integer converter with four rounding modes.
module ftoi_pipe
    import ftoi_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic [1:0]       rm,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] y,
    output logic             nv,
    output logic             nx
);

    localparam int R_W = OUT_W + 1;

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    logic        s1_valid_reg;
    logic [31:0] s1_x_reg;
    logic [1:0]  s1_rm_reg;
    logic        s1_signed_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid_reg <= 1'b0;
        else if (adv)
            s1_valid_reg <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_x_reg      <= x;
            s1_rm_reg     <= rm;
            s1_signed_reg <= is_signed;
        end
    end

    logic             sign_c;
    logic [EXP_W-1:0] exp_c;
    logic [MAN_W-1:0] man_c;
    logic [OUT_W-1:0] int_part_c;
    logic             guard_c;
    logic             sticky_c;
    logic             too_big_c;
    logic             inc_c;

    assign sign_c = s1_x_reg[31];
    assign exp_c  = s1_x_reg[30:23];
    assign man_c  = s1_x_reg[22:0];

    ftoi_align #(.OUT_W(OUT_W)) u_align (
        .e        (exp_c),
        .m        (man_c),
        .int_part (int_part_c),
        .guard    (guard_c),
        .sticky   (sticky_c),
        .too_big  (too_big_c)
    );

    always_comb begin
        inc_c = 1'b0;
        case (s1_rm_reg)
            RM_RNA:  inc_c = guard_c;
            RM_RTZ:  inc_c = 1'b0;
            RM_RDN:  inc_c = sign_c & (guard_c | sticky_c);
            default: inc_c = ~sign_c & (guard_c | sticky_c);
        endcase
    end

    logic             s2_valid_reg;
    logic             s2_sign_reg;
    logic             s2_signed_reg;
    logic [OUT_W-1:0] s2_int_reg;
    logic             s2_inc_reg;
    logic             s2_inexact_reg;
    logic             s2_too_big_reg;
    logic             s2_nan_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s2_valid_reg <= 1'b0;
        else if (adv)
            s2_valid_reg <= s1_valid_reg;
    end

    always_ff @(posedge clk) begin
        if (adv && s1_valid_reg) begin
            s2_sign_reg    <= sign_c;
            s2_signed_reg  <= s1_signed_reg;
            s2_int_reg     <= int_part_c;
            s2_inc_reg     <= inc_c;
            s2_inexact_reg <= guard_c | sticky_c;
            s2_too_big_reg <= too_big_c;
            s2_nan_reg     <= (exp_c == '1) && (man_c != '0);
        end
    end

    // One extra bit on the rounded magnitude catches the carry out of the increment.
    logic [R_W-1:0]   rounded_c;
    logic [OUT_W-1:0] mag_c;
    logic             range_ok_c;
    logic [OUT_W-1:0] y_c;
    logic             nv_c;
    logic             nx_c;

    assign rounded_c = {1'b0, s2_int_reg} + R_W'(s2_inc_reg);
    assign mag_c     = rounded_c[OUT_W-1:0];

    always_comb begin
        range_ok_c = 1'b0;
        if (s2_signed_reg) begin
            if (!s2_sign_reg)
                range_ok_c = (rounded_c[OUT_W:OUT_W-1] == 2'b00);
            else
                range_ok_c = !rounded_c[OUT_W] &&
                             (!rounded_c[OUT_W-1] || (rounded_c[OUT_W-2:0] == '0));
        end else begin
            range_ok_c = s2_sign_reg ? (rounded_c == '0) : !rounded_c[OUT_W];
        end
    end

    always_comb begin
        y_c  = s2_sign_reg ? -mag_c : mag_c;
        nv_c = 1'b0;
        nx_c = s2_inexact_reg;
        if (s2_nan_reg) begin
            y_c  = OUT_W'(sat_value(OUT_W, s2_signed_reg, 1'b0));
            nv_c = 1'b1;
            nx_c = 1'b0;
        end else if (s2_too_big_reg || !range_ok_c) begin
            y_c  = OUT_W'(sat_value(OUT_W, s2_signed_reg, s2_sign_reg));
            nv_c = 1'b1;
            nx_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            nv        <= 1'b0;
            nx        <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid_reg;
            if (s2_valid_reg) begin
                y  <= y_c;
                nv <= nv_c;
                nx <= nx_c;
            end
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Vector table plus stall/reset sequences against a 32-bit and an 8-bit instance, scoreboarded.
module tb_ftoi_pipe;
    import ftoi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] x;
    logic [1:0]  rm;
    logic        sgn;
    logic        iv_a, iv_b, out_ready;
    logic        ir_a, ov_a, nv_a, nx_a;
    logic [31:0] y_a;
    logic        ir_b, ov_b, nv_b, nx_b;
    logic [7:0]  y_b;

    ftoi_pipe #(.OUT_W(32)) dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .x(x), .rm(rm),
        .is_signed(sgn), .out_valid(ov_a), .out_ready(out_ready), .y(y_a), .nv(nv_a), .nx(nx_a)
    );

    ftoi_pipe #(.OUT_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .x(x), .rm(rm),
        .is_signed(sgn), .out_valid(ov_b), .out_ready(out_ready), .y(y_b), .nv(nv_b), .nx(nx_b)
    );

    typedef struct {
        bit          w8;
        logic [31:0] x;
        logic [1:0]  rm;
        logic        sgn;
        logic [31:0] y;
        logic        nv;
        logic        nx;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] y;
        logic        nv;
        logic        nx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur;

    int compared     = 0;
    int mismatched   = 0;
    int stall_cycles = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y     = '0;

    function automatic vec_t mk(input bit w8, input logic [31:0] xv, input logic [1:0] rmv,
                                input logic sv, input logic [31:0] yv, input logic nvv, input logic nxv);
        vec_t v;
        v.w8 = w8; v.x = xv; v.rm = rmv; v.sgn = sv; v.y = yv; v.nv = nvv; v.nx = nxv;
        return v;
    endfunction

    task automatic check_out(input exp_t e, input logic [31:0] gy, input logic gnv,
                             input logic gnx, input bit w8);
        logic [31:0] wy;
        wy = w8 ? (e.y & 32'h0000_00FF) : e.y;
        compared++;
        if (gy !== wy || gnv !== e.nv || gnx !== e.nx) begin
            mismatched++;
            $display("FAIL result_%0d (w%0d): got y=%h nv=%b nx=%b, want y=%h nv=%b nx=%b",
                     e.id, w8 ? 8 : 32, gy, gnv, gnx, wy, e.nv, e.nx);
        end else begin
            $display("ok   result_%0d (w%0d): y=%h nv=%b nx=%b", e.id, w8 ? 8 : 32, gy, gnv, gnx);
        end
    endtask

    // Monitor: inputs and outputs transfer on the next rising edge after this falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                compared++;
                if (ov_a !== 1'b1 || y_a !== prev_y) begin
                    mismatched++;
                    $display("FAIL stall_hold: got out_valid=%b y=%h, want out_valid=1 y=%h", ov_a, y_a, prev_y);
                end
            end
            if (ov_a === 1'b1 && !out_ready) begin
                stall_cycles++;
                compared++;
                if (ir_a !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_in_ready: got in_ready=%b, want 0", ir_a);
                end
            end
            prev_stall = (ov_a === 1'b1) && !out_ready;
            prev_y     = y_a;

            if (ov_a === 1'b1 && out_ready) begin
                if (q_a.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out_w32: got y=%h with no result pending, want none", y_a);
                end else begin
                    e = q_a.pop_front();
                    check_out(e, y_a, nv_a, nx_a, 1'b0);
                end
            end
            if (ov_b === 1'b1 && out_ready) begin
                if (q_b.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out_w8: got y=%h with no result pending, want none", y_b);
                end else begin
                    e = q_b.pop_front();
                    check_out(e, {24'd0, y_b}, nv_b, nx_b, 1'b1);
                end
            end
            if (iv_a && ir_a === 1'b1) q_a.push_back(cur);
            if (iv_b && ir_b === 1'b1) q_b.push_back(cur);
        end
    end

    task automatic issue(input vec_t v, input int id);
        int waited;
        waited = 0;
        x = v.x; rm = v.rm; sgn = v.sgn;
        cur.id = id; cur.y = v.y; cur.nv = v.nv; cur.nx = v.nx;
        iv_a = !v.w8;
        iv_b = v.w8;
        forever begin
            @(negedge clk);
            if ((v.w8 ? ir_b : ir_a) === 1'b1) break;
            waited++;
            if (waited > 20) begin
                compared++;
                mismatched++;
                $display("FAIL issue_timeout_%0d: got in_ready=0 for %0d cycles, want 1", id, waited);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        iv_a = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        compared++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            mismatched++;
            $display("FAIL drain_%s: got %0d/%0d results outstanding, want 0/0", tag, q_a.size(), q_b.size());
        end
    endtask

    vec_t vt[$];
    vec_t st[$];

    initial begin
        int k;
        rst = 1'b1; iv_a = 1'b0; iv_b = 1'b0; x = '0; rm = '0; sgn = 1'b0; out_ready = 1'b1;

        vt.push_back(mk(0, 32'h4020_0000, RM_RNA, 1, 32'd3,         0, 1));
        vt.push_back(mk(0, 32'h4020_0000, RM_RTZ, 1, 32'd2,         0, 1));
        vt.push_back(mk(0, 32'h4020_0000, RM_RDN, 1, 32'd2,         0, 1));
        vt.push_back(mk(0, 32'h4020_0000, RM_RUP, 1, 32'd3,         0, 1));
        vt.push_back(mk(0, 32'hC020_0000, RM_RNA, 1, 32'hFFFF_FFFD, 0, 1));
        vt.push_back(mk(0, 32'hC020_0000, RM_RTZ, 1, 32'hFFFF_FFFE, 0, 1));
        vt.push_back(mk(0, 32'hC020_0000, RM_RDN, 1, 32'hFFFF_FFFD, 0, 1));
        vt.push_back(mk(0, 32'hC020_0000, RM_RUP, 1, 32'hFFFF_FFFE, 0, 1));
        vt.push_back(mk(0, 32'h4F00_0000, RM_RTZ, 1, 32'h7FFF_FFFF, 1, 0));
        vt.push_back(mk(0, 32'hCF00_0000, RM_RTZ, 1, 32'h8000_0000, 0, 0));
        vt.push_back(mk(0, 32'hCF00_0001, RM_RTZ, 1, 32'h8000_0000, 1, 0));
        vt.push_back(mk(0, 32'h4F00_0000, RM_RTZ, 0, 32'h8000_0000, 0, 0));
        vt.push_back(mk(0, 32'h7FC0_0000, RM_RNA, 1, 32'h7FFF_FFFF, 1, 0));
        vt.push_back(mk(0, 32'h7FC0_0000, RM_RNA, 0, 32'hFFFF_FFFF, 1, 0));
        vt.push_back(mk(0, 32'h7F80_0000, RM_RNA, 1, 32'h7FFF_FFFF, 1, 0));
        vt.push_back(mk(0, 32'hFF80_0000, RM_RNA, 1, 32'h8000_0000, 1, 0));
        vt.push_back(mk(0, 32'hFF80_0000, RM_RUP, 0, 32'h0000_0000, 1, 0));
        vt.push_back(mk(0, 32'h4F80_0000, RM_RTZ, 0, 32'hFFFF_FFFF, 1, 0));
        vt.push_back(mk(0, 32'h4F7F_FFFF, RM_RTZ, 0, 32'hFFFF_FF00, 0, 0));
        vt.push_back(mk(0, 32'h0000_0000, RM_RUP, 1, 32'h0000_0000, 0, 0));
        vt.push_back(mk(0, 32'h8000_0000, RM_RDN, 0, 32'h0000_0000, 0, 0));
        vt.push_back(mk(0, 32'h0000_0001, RM_RUP, 1, 32'h0000_0001, 0, 1));
        vt.push_back(mk(0, 32'h8000_0001, RM_RDN, 1, 32'hFFFF_FFFF, 0, 1));
        vt.push_back(mk(0, 32'h3F00_0000, RM_RNA, 1, 32'h0000_0001, 0, 1));
        vt.push_back(mk(0, 32'h3EFF_FFFF, RM_RNA, 1, 32'h0000_0000, 0, 1));
        vt.push_back(mk(0, 32'hBF80_0000, RM_RNA, 0, 32'h0000_0000, 1, 0));
        vt.push_back(mk(0, 32'h3FC0_0000, RM_RTZ, 1, 32'h0000_0001, 0, 1));
        vt.push_back(mk(1, 32'h42FF_0000, RM_RNA, 1, 32'h7F, 1, 0));
        vt.push_back(mk(1, 32'hBF00_0000, RM_RTZ, 0, 32'h00, 0, 1));
        vt.push_back(mk(1, 32'hBF00_0000, RM_RDN, 0, 32'h00, 1, 0));
        vt.push_back(mk(1, 32'h4300_0000, RM_RTZ, 0, 32'h80, 0, 0));
        vt.push_back(mk(1, 32'h437F_8000, RM_RNA, 0, 32'hFF, 1, 0));
        vt.push_back(mk(1, 32'hC300_0000, RM_RTZ, 1, 32'h80, 0, 0));
        vt.push_back(mk(1, 32'h4380_0000, RM_RTZ, 0, 32'hFF, 1, 0));
        vt.push_back(mk(1, 32'h4300_0000, RM_RTZ, 1, 32'h7F, 1, 0));
        vt.push_back(mk(1, 32'hC301_0000, RM_RTZ, 1, 32'h80, 1, 0));

        st.push_back(mk(0, 32'h3F80_0000, RM_RTZ, 1, 32'd1, 0, 0));
        st.push_back(mk(0, 32'h4000_0000, RM_RTZ, 1, 32'd2, 0, 0));
        st.push_back(mk(0, 32'h4040_0000, RM_RTZ, 1, 32'd3, 0, 0));
        st.push_back(mk(0, 32'h4080_0000, RM_RTZ, 1, 32'd4, 0, 0));
        st.push_back(mk(0, 32'h40A0_0000, RM_RTZ, 1, 32'd5, 0, 0));
        st.push_back(mk(0, 32'h40C0_0000, RM_RTZ, 1, 32'd6, 0, 0));
        st.push_back(mk(0, 32'h40E0_0000, RM_RTZ, 1, 32'd7, 0, 0));
        st.push_back(mk(0, 32'h4100_0000, RM_RTZ, 1, 32'd8, 0, 0));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        compared++;
        if (ov_a !== 1'b0 || y_a !== '0 || nv_a !== 1'b0 || nx_a !== 1'b0 || ir_a !== 1'b1 ||
            ov_b !== 1'b0 || y_b !== '0 || nv_b !== 1'b0 || nx_b !== 1'b0 || ir_b !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_state: got ov=%b/%b y=%h/%h nv=%b/%b nx=%b/%b ir=%b/%b, want all 0 and in_ready 1",
                     ov_a, ov_b, y_a, y_b, nv_a, nv_b, nx_a, nx_b, ir_a, ir_b);
        end
        @(posedge clk); #1;

        foreach (vt[i]) issue(vt[i], i);
        idle();
        drain("table");

        // Back-to-back stream with a 4-cycle consumer stall in the middle.
        stall_cycles = 0;
        fork
            begin
                foreach (st[i]) issue(st[i], 100 + i);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stream");
        compared++;
        if (stall_cycles < 4) begin
            mismatched++;
            $display("FAIL stall_observed: got %0d stalled cycles, want >= 4", stall_cycles);
        end

        // Three operations in flight, then a one-cycle reset.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(st[i], 200 + i);
        idle();
        @(negedge clk);
        compared++;
        if (ov_a !== 1'b1) begin
            mismatched++;
            $display("FAIL inflight_valid: got out_valid=%b, want 1", ov_a);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
            mismatched++;
            $display("FAIL after_reset: got out_valid=%b in_ready=%b, want 0 and 1", ov_a, ir_a);
        end
        repeat (6) @(posedge clk);
        #1;

        issue(st[6], 300);
        idle();
        k = 0;
        for (int c = 1; c <= 8; c++) begin
            if (k == 0) begin
                @(negedge clk);
                if (ov_a === 1'b1) k = c;
            end
        end
        compared++;
        if (k != 3) begin
            mismatched++;
            $display("FAIL latency: got out_valid after %0d cycles (0 = never), want 3", k);
        end
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
